// File: rtl/sumador_simd_segmentado_if.sv
// Handshake and data bundle for the pipelined SIMD adder/subtractor.
//   master : producer/consumer side (drives A/B/Cin/modo/in_valid, out_ready)
//   slave  : the adder (drives in_ready, S/Cout/sat/out_valid)
// Lane i occupies bits [i*ANCHO_LANE +: ANCHO_LANE] of A, B and S.
interface sumador_simd_segmentado_if #(
   parameter int ANCHO_LANE = 4,
   parameter int N_LANES    = 4
);
   logic                            in_valid;
   logic                            in_ready;
   logic [1:0]                      modo;
   logic [N_LANES*ANCHO_LANE-1:0]   A;
   logic [N_LANES*ANCHO_LANE-1:0]   B;
   logic                            Cin;
   logic [N_LANES*ANCHO_LANE-1:0]   S;
   logic [N_LANES-1:0]              Cout;
   logic [N_LANES-1:0]              sat;
   logic                            out_valid;
   logic                            out_ready;

   modport master (
      output in_valid, modo, A, B, Cin, out_ready,
      input  in_ready, S, Cout, sat, out_valid
   );

   modport slave (
      input  in_valid, modo, A, B, Cin, out_ready,
      output in_ready, S, Cout, sat, out_valid
   );
endinterface

// File: rtl/sumador_simd_segmentado.sv
// Pipelined SIMD adder/subtractor, N_LANES lanes of ANCHO_LANE bits, 2-cycle
// latency, 1 result/cycle, valid/ready on both sides with a global stall.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : sumador_simd_segmentado_if.slave
//              modo 00 add, 01 sub, 10 chained add, 11 chained sub
//              Cout per lane (sub: 1 = no borrow), sat per lane
// Optional feature: define SUMADOR_SAT_EN for per-lane saturation in the
// non-chained modes; otherwise results wrap and sat is tied to 0.

// One lane: {co, s} = a + x + ci
module sumador_simd_lane #(
   parameter int ANCHO = 4
) (
   input  logic [ANCHO-1:0] a,
   input  logic [ANCHO-1:0] x,
   input  logic             ci,
   output logic [ANCHO-1:0] s,
   output logic             co
);
   assign {co, s} = {1'b0, a} + {1'b0, x} + {{ANCHO{1'b0}}, ci};
endmodule

module sumador_simd_segmentado #(
   parameter int ANCHO_LANE = 4,
   parameter int N_LANES    = 4
) (
   input logic                       clk,
   input logic                       rst,
   sumador_simd_segmentado_if.slave  bus
);
   localparam int W = N_LANES * ANCHO_LANE;

   // vld_pipe[1] = stage-1 valid, vld_pipe[2] = out_valid
   logic [2:1]          vld_pipe;
   logic                avanzar;
   logic [W-1:0]        a_q, b_q;
   logic                cin_q;
   logic [1:0]          modo_q;
   logic [W-1:0]        s_q;
   logic [N_LANES-1:0]  cout_q, sat_q;

   logic [W-1:0]        suma;
   logic [N_LANES-1:0]  cout_c, sat_c;
   logic                c0;

   // Whole pipeline moves together; out_valid is 0 during reset so in_ready=1.
   assign avanzar      = !vld_pipe[2] | bus.out_ready;
   assign bus.in_ready = avanzar;

   // Subtraction forces the lane-0 carry to 1 (two's complement of B);
   // add uses Cin. Non-chained lanes all share this carry.
   assign c0 = modo_q[0] | cin_q;

   for (genvar l = 0; l < N_LANES; l++) begin : g_lane
      logic                  ci, co;
      logic [ANCHO_LANE-1:0] b_l, x_l, s_l;

      assign b_l = b_q[l*ANCHO_LANE +: ANCHO_LANE];
      assign x_l = modo_q[0] ? ~b_l : b_l;

      if (l == 0) begin : g_first
         assign ci = c0;
      end else begin : g_rest
         // Chained modes ripple the previous lane's carry in.
         assign ci = modo_q[1] ? g_lane[l-1].co : c0;
      end

      sumador_simd_lane #(.ANCHO(ANCHO_LANE)) u_lane (
         .a  (a_q[l*ANCHO_LANE +: ANCHO_LANE]),
         .x  (x_l),
         .ci (ci),
         .s  (s_l),
         .co (co)
      );

      assign cout_c[l] = co;

`ifdef SUMADOR_SAT_EN
      // Add overflows on carry, sub underflows on missing carry (borrow).
      logic ovf;
      assign ovf       = !modo_q[1] & (modo_q[0] ? !co : co);
      assign sat_c[l]  = ovf;
      assign suma[l*ANCHO_LANE +: ANCHO_LANE] = ovf ? {ANCHO_LANE{!modo_q[0]}} : s_l;
`else
      assign suma[l*ANCHO_LANE +: ANCHO_LANE] = s_l;
`endif
   end

`ifndef SUMADOR_SAT_EN
   assign sat_c = '0;
`endif

   // Data registers only load on valid beats so outputs keep their reset
   // value until the first real result and hold across bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cin_q    <= 1'b0;
         modo_q   <= 2'b00;
         s_q      <= '0;
         cout_q   <= '0;
         sat_q    <= '0;
      end else if (avanzar) begin
         vld_pipe[1] <= bus.in_valid;
         vld_pipe[2] <= vld_pipe[1];
         if (bus.in_valid) begin
            a_q    <= bus.A;
            b_q    <= bus.B;
            cin_q  <= bus.Cin;
            modo_q <= bus.modo;
         end
         if (vld_pipe[1]) begin
            s_q    <= suma;
            cout_q <= cout_c;
            sat_q  <= sat_c;
         end
      end
   end

   assign bus.S         = s_q;
   assign bus.Cout      = cout_q;
   assign bus.sat       = sat_q;
   assign bus.out_valid = vld_pipe[2];
endmodule

// File: tb/tb_sumador_simd_segmentado.sv
// Self-checking bench for sumador_simd_segmentado (ANCHO_LANE=4, N_LANES=4).
// Expected results are queued on each accepted input and compared on each
// output transfer; a few extra direct checks cover reset and backpressure.
module tb_sumador_simd_segmentado;
   typedef struct {
      logic [15:0] s;
      logic [3:0]  co;
      logic [3:0]  sat;
      string       tag;
   } exp_t;

   logic clk, rst;
   int   n_tests, n_fail, n_out;
   exp_t q[$];

   sumador_simd_segmentado_if #(.ANCHO_LANE(4), .N_LANES(4)) bus ();

   sumador_simd_segmentado #(.ANCHO_LANE(4), .N_LANES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] m, input logic [15:0] a, b,
                                  input logic cin, input string tag);
      exp_t        e;
      logic [15:0] x;
      logic [16:0] t, mask;
      logic        c;
      int          al, xl, tl;
      x = m[0] ? ~b : b;
      c = m[0] ? 1'b1 : cin;
      e.s = '0; e.co = '0; e.sat = '0; e.tag = tag;
      if (m[1]) begin
         // Whole-word arithmetic; each lane carry is the carry out of the
         // low (l+1)*4 bits.
         for (int l = 0; l < 4; l++) begin
            mask = (17'h1 << ((l+1)*4)) - 17'h1;
            t = ({1'b0, a} & mask) + ({1'b0, x} & mask) + {16'h0, c};
            e.co[l] = t[(l+1)*4];
         end
         t = {1'b0, a} + {1'b0, x} + {16'h0, c};
         e.s = t[15:0];
      end else begin
         for (int l = 0; l < 4; l++) begin
            al = int'(a[l*4 +: 4]);
            xl = int'(x[l*4 +: 4]);
            tl = al + xl + int'(c);
            e.s[l*4 +: 4] = 4'(tl);
            e.co[l] = tl > 15;
`ifdef SUMADOR_SAT_EN
            if (!m[0] && e.co[l]) begin e.s[l*4 +: 4] = 4'hF; e.sat[l] = 1'b1; end
            if (m[0] && !e.co[l]) begin e.s[l*4 +: 4] = 4'h0; e.sat[l] = 1'b1; end
`endif
         end
      end
      return e;
   endfunction

   // Output side of the scoreboard: a transfer happens at the next rising
   // edge whenever out_valid & out_ready are seen here.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         n_out++;
         if (q.size() == 0) begin
            chk("unexpected_out", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, "_S"},    32'(bus.S),    32'(e.s));
            chk({e.tag, "_Cout"}, 32'(bus.Cout), 32'(e.co));
            chk({e.tag, "_sat"},  32'(bus.sat),  32'(e.sat));
         end
      end
   end

   bit rnd_rdy;

   task automatic send(input logic [1:0] m, input logic [15:0] a, b, input logic cin,
                       input bit use_exp, input exp_t ex, input string tag);
      bit acc;
      int n;
      bus.modo = m; bus.A = a; bus.B = b; bus.Cin = cin; bus.in_valid = 1'b1;
      acc = 1'b0; n = 0;
      while (!acc && n < 200) begin
         if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (bus.in_ready) begin
            acc = 1'b1;
            if (use_exp) q.push_back(ex);
            else         q.push_back(model(m, a, b, cin, tag));
         end
         @(posedge clk); #1;
         n++;
      end
      if (!acc) chk({tag, "_accept_timeout"}, 0, 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      bus.out_ready = 1'b1;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_drain"}, 32'(q.size()), 0);
   endtask

   exp_t        e;
   logic [15:0] bp_a[3], bp_b[3], s_hold;
   int          k, n0, n;

   initial begin
      n_tests = 0; n_fail = 0; n_out = 0; rnd_rdy = 1'b0;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.modo = 2'b00; bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
      bus.out_ready = 1'b1;
      #3;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_S",         32'(bus.S),         0);
      chk("rst_Cout",      32'(bus.Cout),      0);
      chk("rst_sat",       32'(bus.sat),       0);
      chk("rst_in_ready",  32'(bus.in_ready),  1);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Vectors with hand-derived results
      e = '{16'h3F0F, 4'b0010, 4'b0000, "add"};
      send(2'b00, 16'h21F1, 16'h1E1E, 1'b0, 1, e, "add");
      e = '{16'h02F1, 4'b1101, 4'b0000, "sub"};
      send(2'b01, 16'h0512, 16'h0321, 1'b0, 1, e, "sub");
      e = '{16'h1000, 4'b0111, 4'b0000, "chain_add"};
      send(2'b10, 16'h0FFF, 16'h0000, 1'b1, 1, e, "chain_add");
      e = '{16'h0000, 4'b0000, 4'b0000, "chain_sub"};  // 0x1234-0x1234
      e.co = 4'b1111;
      send(2'b11, 16'h1234, 16'h1234, 1'b1, 1, e, "chain_sub");
`ifdef SUMADOR_SAT_EN
      e = '{16'h000F, 4'b0001, 4'b0001, "sat_add"};
`else
      e = '{16'h0000, 4'b0001, 4'b0000, "sat_add"};
`endif
      send(2'b00, 16'h000F, 16'h0001, 1'b0, 1, e, "sat_add");
      drain("directed");

      // First result appears one edge after the accept edge's successor
      bus.modo = 2'b00; bus.A = 16'h1111; bus.B = 16'h2222; bus.Cin = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      q.push_back(model(2'b00, 16'h1111, 16'h2222, 1'b0, "lat"));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("lat_not_yet", 32'(bus.out_valid), 0);
      @(posedge clk); #1;
      chk("lat_valid", 32'(bus.out_valid), 1);
      drain("lat");

      // Backpressure: with the consumer stalled only two inputs fit
      bp_a[0] = 16'h1234; bp_b[0] = 16'h4321;
      bp_a[1] = 16'hFFFF; bp_b[1] = 16'h0001;
      bp_a[2] = 16'h8000; bp_b[2] = 16'h7FFF;
      bus.out_ready = 1'b0; k = 0; s_hold = '0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         bus.modo = 2'b00; bus.A = bp_a[k]; bus.B = bp_b[k]; bus.Cin = 1'b0;
         bus.in_valid = 1'b1;
         @(negedge clk);
         if (bus.in_ready) begin
            q.push_back(model(2'b00, bp_a[k], bp_b[k], 1'b0, "bp"));
            k++;
         end
         if (cyc == 3) s_hold = bus.S;
         @(posedge clk); #1;
      end
      chk("bp_accepted",  32'(k), 2);
      chk("bp_in_ready",  32'(bus.in_ready), 0);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_S_stable",  32'(bus.S), 32'(s_hold));
      n0 = n_out; n = 0;
      bus.out_ready = 1'b1;
      while (k < 3 && n < 20) begin
         @(negedge clk);
         if (bus.in_ready) begin
            q.push_back(model(2'b00, bp_a[2], bp_b[2], 1'b0, "bp"));
            k++;
         end
         @(posedge clk); #1;
         n++;
      end
      bus.in_valid = 1'b0;
      drain("bp");
      chk("bp_out_count", 32'(n_out - n0), 3);

      // Random traffic with random consumer stalls and input bubbles
      rnd_rdy = 1'b1;
      for (int i = 0; i < 80; i++) begin
         send(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 1)), 0, e, "rnd");
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
      rnd_rdy = 1'b0;
      drain("rnd");

      // Reset while a result is being held at the output
      bus.out_ready = 1'b0;
      send(2'b00, 16'h1111, 16'h1111, 1'b0, 0, e, "mid");
      repeat (2) begin @(posedge clk); #1; end
      chk("pre_rst_out_valid", 32'(bus.out_valid), 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
      chk("mid_rst_S",         32'(bus.S),         0);
      chk("mid_rst_Cout",      32'(bus.Cout),      0);
      chk("mid_rst_sat",       32'(bus.sat),       0);
      chk("mid_rst_in_ready",  32'(bus.in_ready),  1);
      q.delete();
      n0 = n_out;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      chk("post_rst_out_valid", 32'(bus.out_valid), 0);
      chk("post_rst_no_stale",  32'(n_out - n0), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
